// File: rtl/and_vector_driver_pkg.sv
// Shared types and helpers for the AND-gate vector driver.
// Holds the FSM state encoding and the golden AND reference.
package and_tb_pkg;

    typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

    localparam int MAX_VEC = 4;

    function automatic logic exp_and(input logic [1:0] idx);
        return idx[0] & idx[1];
    endfunction

endpackage

// File: rtl/and_vector_driver_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Used for the per-run mismatch count.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/and_vector_driver.sv
// Clocked exhaustive stimulus/check stage for a 2-input AND gate:
// drives a/b per vector, samples r after a hold period, tallies mismatches.
module and_vector_driver
    import and_tb_pkg::*;
#(
    parameter int N_VEC       = 4,
    parameter int HOLD_CYCLES = 4,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             a,
    output logic             b,
    input  logic             r,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             mismatch,
    output logic [ERR_W-1:0] err_cnt,
    output logic [1:0]       first_fail,
    output logic [1:0]       vec_idx
);

    localparam int             NV        = (N_VEC > MAX_VEC) ? MAX_VEC : N_VEC;
    localparam int             HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [1:0]     LAST_VEC  = 2'(NV - 1);

    state_t        state_q, state_d;
    logic [1:0]    vec_q, vec_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          a_q, a_d, b_q, b_d;
    logic          busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic          mm_q, mm_d;
    logic [1:0]    ff_q, ff_d;
    logic          err_clr, err_inc, mm_now;

    sat_counter #(.W(ERR_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (err_clr),
        .inc   (err_inc),
        .cnt   (err_cnt)
    );

    // Compare against what is actually on the pins, not the internal index.
    assign mm_now = (r != exp_and({b_q, a_q}));

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        hold_d  = hold_q;
        a_d     = a_q;
        b_d     = b_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        ff_d    = ff_q;
        mm_d    = 1'b0;
        err_clr = 1'b0;
        err_inc = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = APPLY;
                    vec_d   = '0;
                    hold_d  = '0;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    ff_d    = '0;
                    err_clr = 1'b1;
                end
            end
            APPLY: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = SAMPLE;
                    hold_d  = '0;
                end else begin
                    hold_d  = hold_q + 1'b1;
                end
            end
            SAMPLE: begin
                if (mm_now) begin
                    mm_d    = 1'b1;
                    err_inc = 1'b1;
                    if (err_cnt == '0) ff_d = vec_q;
                end
                if (vec_q == LAST_VEC) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_cnt == '0) && !mm_now;
                end else begin
                    state_d = APPLY;
                    vec_d   = vec_q + 1'b1;
                    a_d     = vec_d[0];
                    b_d     = vec_d[1];
                    hold_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            hold_q  <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            mm_q    <= 1'b0;
            ff_q    <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            hold_q  <= hold_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            mm_q    <= mm_d;
            ff_q    <= ff_d;
        end
    end

    assign a          = a_q;
    assign b          = b_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign mismatch   = mm_q;
    assign first_fail = ff_q;
    assign vec_idx    = vec_q;

endmodule

// File: tb/tb_and_vector_driver.sv
// Bench for and_vector_driver: three instances (defaults, ERR_W=1, HOLD_CYCLES=1),
// each fed by a truth-table "DUT" whose expected results come from a small run model.
module tb_and_vector_driver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] start = '0;
    logic [2:0] a_w, b_w, r_w, busy_w, done_w, pass_w, mm_w;
    logic [7:0] err_w [3];
    logic [1:0] ff_w  [3];
    logic [1:0] vi_w  [3];
    logic [3:0] tt    [3];
    logic       err1;
    logic [7:0] err0, err2;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_r
        assign r_w[k] = tt[k][{b_w[k], a_w[k]}];
    end

    assign err_w[0] = err0;
    assign err_w[1] = {7'b0, err1};
    assign err_w[2] = err2;

    and_vector_driver u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .a(a_w[0]), .b(b_w[0]), .r(r_w[0]),
        .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .mismatch(mm_w[0]),
        .err_cnt(err0), .first_fail(ff_w[0]), .vec_idx(vi_w[0])
    );

    and_vector_driver #(.ERR_W(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .a(a_w[1]), .b(b_w[1]), .r(r_w[1]),
        .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .mismatch(mm_w[1]),
        .err_cnt(err1), .first_fail(ff_w[1]), .vec_idx(vi_w[1])
    );

    and_vector_driver #(.HOLD_CYCLES(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .a(a_w[2]), .b(b_w[2]), .r(r_w[2]),
        .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]), .mismatch(mm_w[2]),
        .err_cnt(err2), .first_fail(ff_w[2]), .vec_idx(vi_w[2])
    );

    task automatic check(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    endtask

    task automatic check_zero(input int sel, input string tag);
        check({tag, "_a"},     a_w[sel],    0);
        check({tag, "_b"},     b_w[sel],    0);
        check({tag, "_busy"},  busy_w[sel], 0);
        check({tag, "_done"},  done_w[sel], 0);
        check({tag, "_pass"},  pass_w[sel], 0);
        check({tag, "_mm"},    mm_w[sel],   0);
        check({tag, "_err"},   err_w[sel],  0);
        check({tag, "_ff"},    ff_w[sel],   0);
        check({tag, "_vidx"},  vi_w[sel],   0);
    endtask

    // Full run on instance sel with DUT truth table t; pulse_at>0 re-asserts start mid-run.
    task automatic run(input int sel, input logic [3:0] t, input int hold,
                       input int errmax, input int pulse_at, input string tag);
        int nmis, first, exp_err, cyc, pulses;
        bit abok;
        nmis = 0;
        first = -1;
        for (int i = 0; i < 4; i++) begin
            if (t[i] != (i == 3)) begin
                nmis++;
                if (first < 0) first = i;
            end
        end
        exp_err = (nmis > errmax) ? errmax : nmis;
        tt[sel] = t;

        @(posedge clk); #1 start[sel] = 1'b1;
        @(posedge clk); #1 start[sel] = 1'b0;
        check({tag, "_busy_on_start"}, busy_w[sel], 1);
        check({tag, "_err_cleared"},   err_w[sel],  0);
        check({tag, "_done_cleared"},  done_w[sel], 0);

        cyc = 0;
        pulses = 0;
        abok = 1'b1;
        while (!done_w[sel] && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            start[sel] = (cyc == pulse_at);
            if (busy_w[sel] && (a_w[sel] != vi_w[sel][0] || b_w[sel] != vi_w[sel][1])) abok = 1'b0;
            if (mm_w[sel]) pulses++;
        end
        start[sel] = 1'b0;

        check({tag, "_latency"},    cyc,          4 * (hold + 1));
        check({tag, "_done"},       done_w[sel],  1);
        check({tag, "_busy_off"},   busy_w[sel],  0);
        check({tag, "_err_cnt"},    err_w[sel],   exp_err);
        check({tag, "_first_fail"}, ff_w[sel],    (first < 0) ? 0 : first);
        check({tag, "_pass"},       pass_w[sel],  (nmis == 0) ? 1 : 0);
        check({tag, "_mm_pulses"},  pulses,       nmis);
        check({tag, "_ab_track"},   abok,         1);
        check({tag, "_vidx_last"},  vi_w[sel],    3);
        check({tag, "_ab_held"},    {a_w[sel], b_w[sel]}, 3);
        @(posedge clk); #1;
        check({tag, "_mm_one_cycle"}, mm_w[sel],   0);
        check({tag, "_done_held"},    done_w[sel], 1);
        check({tag, "_err_held"},     err_w[sel],  exp_err);
    endtask

    initial begin
        int wait_cyc;
        for (int k = 0; k < 3; k++) tt[k] = 4'b1000;

        repeat (2) @(posedge clk);
        #1;
        check_zero(0, "reset");
        check_zero(1, "reset1");
        rst_n = 1'b1;

        run(0, 4'b1000, 4, 255, 0, "golden");
        run(0, 4'b1111, 4, 255, 0, "force1");
        run(0, 4'b1110, 4, 255, 0, "or_gate");
        run(0, 4'b1110, 4, 255, 0, "or_gate_rerun");
        run(1, 4'b1111, 4, 1,   0, "sat_w1");
        run(2, 4'b1000, 1, 255, 5, "hold1_restart");
        run(2, 4'b0111, 1, 255, 3, "hold1_nand");

        for (int n = 0; n < 4; n++) begin
            run(0, 4'($urandom_range(0, 15)), 4, 255, 0, "rand");
            run(1, 4'($urandom_range(0, 15)), 4, 1, 0, "rand_w1");
        end

        // Asynchronous reset in the middle of vector 2, then a clean rerun.
        tt[0] = 4'b1111;
        @(posedge clk); #1 start[0] = 1'b1;
        @(posedge clk); #1 start[0] = 1'b0;
        wait_cyc = 0;
        while (vi_w[0] != 2'd2 && wait_cyc < 100) begin
            @(posedge clk); #1;
            wait_cyc++;
        end
        check("rst_reach_vec2", vi_w[0], 2);
        #2 rst_n = 1'b0;
        #1;
        check_zero(0, "midrun_reset");
        repeat (3) @(posedge clk);
        #1;
        check_zero(0, "reset_held");
        rst_n = 1'b1;
        run(0, 4'b1000, 4, 255, 0, "after_reset");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
